// File: rtl/video_timing_meas.sv
// Video timing measurement: measures active/total pixels per line and lines per frame
// from a DE/hsync/vsync stream, counts frames per second, and reports timing lock.
module video_timing_meas #(
  parameter int PXL_CLK_FREQ_HZ = 74_250_000,
  parameter int CNT_W           = 16,
  parameter int FPS_W           = 8,
  parameter int CLK_PER_PIXEL   = 1,
  parameter int STABLE_FRAMES   = 3
) (
  input  logic             pxl_clk,
  input  logic             rst,
  input  logic             video_de,
  input  logic             video_hsync,
  input  logic             video_vsync,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_active,
  output logic [CNT_W-1:0] v_total,
  output logic             meas_valid,
  output logic [FPS_W-1:0] fps,
  output logic             fps_valid,
  output logic             locked,
  output logic             timing_changed
);

  localparam int TICK_W = (PXL_CLK_FREQ_HZ > 1) ? $clog2(PXL_CLK_FREQ_HZ) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PXL_CLK_FREQ_HZ - 1);
  localparam logic [3:0] MATCH_MAX = 4'(STABLE_FRAMES);
  localparam logic [3:0] LOCK_AT   = 4'(STABLE_FRAMES - 1);

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  function automatic logic [FPS_W-1:0] fps_sat_inc(input logic [FPS_W-1:0] c);
    return (c == {FPS_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] per_pixel(input logic [CNT_W-1:0] c);
    return (CLK_PER_PIXEL == 2) ? (c >> 1) : c;
  endfunction

  logic             de_p0, hs_p0, vs_p0;
  logic             de_rise, de_fall, hs_rise, vs_rise;
  logic [CNT_W-1:0] de_len, line_len;
  logic [CNT_W-1:0] h_active_lat, h_total_lat;
  logic [CNT_W-1:0] de_lines, hs_lines;
  logic             line_armed, frame_armed;
  logic [3:0]       match_cnt, match_inc;
  logic [TICK_W-1:0] tick_cnt;
  logic             tick;
  logic [FPS_W-1:0] vs_win, vs_win_close;
  logic             same_set, prev_nonzero;

  assign de_rise = video_de & ~de_p0;
  assign de_fall = ~video_de & de_p0;
  assign hs_rise = video_hsync & ~hs_p0;
  assign vs_rise = video_vsync & ~vs_p0;

  assign tick         = (tick_cnt == TICK_LAST);
  assign vs_win_close = vs_rise ? fps_sat_inc(vs_win) : vs_win;

  assign same_set     = (h_active_lat == h_active) && (h_total_lat == h_total) &&
                        (de_lines == v_active) && (hs_lines == v_total);
  assign prev_nonzero = |{h_active, h_total, v_active, v_total};
  assign match_inc    = (match_cnt >= MATCH_MAX) ? MATCH_MAX : match_cnt + 4'd1;

  always_ff @(posedge pxl_clk) begin
    if (rst) begin
      de_p0          <= 1'b0;
      hs_p0          <= 1'b0;
      vs_p0          <= 1'b0;
      de_len         <= '0;
      line_len       <= '0;
      h_active_lat   <= '0;
      h_total_lat    <= '0;
      de_lines       <= '0;
      hs_lines       <= '0;
      line_armed     <= 1'b0;
      frame_armed    <= 1'b0;
      match_cnt      <= '0;
      tick_cnt       <= '0;
      vs_win         <= '0;
      h_active       <= '0;
      h_total        <= '0;
      v_active       <= '0;
      v_total        <= '0;
      meas_valid     <= 1'b0;
      fps            <= '0;
      fps_valid      <= 1'b0;
      locked         <= 1'b0;
      timing_changed <= 1'b0;
    end else begin
      // p0: input registers for edge detection
      de_p0          <= video_de;
      hs_p0          <= video_hsync;
      vs_p0          <= video_vsync;
      meas_valid     <= 1'b0;
      fps_valid      <= 1'b0;
      timing_changed <= 1'b0;

      // Horizontal: DE width latched at DE fall, line period latched at DE rise
      if (video_de)
        de_len <= de_rise ? CNT_W'(1) : cnt_sat_inc(de_len);
      if (de_fall)
        h_active_lat <= per_pixel(de_len);
      if (de_rise) begin
        line_len   <= CNT_W'(1);
        line_armed <= 1'b1;
        if (line_armed)
          h_total_lat <= per_pixel(line_len);
      end else begin
        line_len <= cnt_sat_inc(line_len);
      end

      // Vertical: edges coincident with the vsync rise belong to the new frame
      if (vs_rise) begin
        de_lines    <= {{(CNT_W-1){1'b0}}, de_rise};
        hs_lines    <= {{(CNT_W-1){1'b0}}, hs_rise};
        frame_armed <= 1'b1;
        if (frame_armed) begin
          h_active   <= h_active_lat;
          h_total    <= h_total_lat;
          v_active   <= de_lines;
          v_total    <= hs_lines;
          meas_valid <= 1'b1;
          if (same_set && (de_lines != '0)) begin
            match_cnt <= match_inc;
            locked    <= (match_inc >= LOCK_AT);
          end else begin
            match_cnt      <= '0;
            locked         <= 1'b0;
            timing_changed <= prev_nonzero;
          end
        end
      end else begin
        if (de_rise)
          de_lines <= cnt_sat_inc(de_lines);
        if (hs_rise)
          hs_lines <= cnt_sat_inc(hs_lines);
      end

      // One-second window; an empty window means the source has gone away
      if (tick) begin
        tick_cnt  <= '0;
        vs_win    <= '0;
        fps       <= vs_win_close;
        fps_valid <= 1'b1;
        if (vs_win_close == '0)
          locked <= 1'b0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
        if (vs_rise)
          vs_win <= fps_sat_inc(vs_win);
      end
    end
  end

endmodule

// File: tb/tb_video_timing_meas.sv
// Directed bench for video_timing_meas: 20-clk lines, 10-line frames, 2000-cycle fps window.
module tb_video_timing_meas;

  logic pxl_clk = 1'b0;
  logic rst = 1'b1;
  logic de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic de2 = 1'b0, hs2 = 1'b0, vs2 = 1'b0;

  logic [15:0] h_active, h_total, v_active, v_total;
  logic        meas_valid, fps_valid, locked, timing_changed;
  logic [7:0]  fps;

  logic [3:0]  s_h_active, s_h_total, s_v_active, s_v_total;
  logic        s_meas_valid, s_fps_valid, s_locked, s_timing_changed;
  logic [7:0]  s_fps;

  logic [15:0] d_h_active, d_h_total, d_v_active, d_v_total;
  logic        d_meas_valid, d_fps_valid, d_locked, d_timing_changed;
  logic [7:0]  d_fps;

  int checks = 0;
  int errors = 0;
  int mv_cnt = 0, fv_cnt = 0, tc_cnt = 0, last_fps = -1;

  always #5 pxl_clk = ~pxl_clk;

  video_timing_meas #(.PXL_CLK_FREQ_HZ(2000), .CNT_W(16), .FPS_W(8),
                      .CLK_PER_PIXEL(1), .STABLE_FRAMES(3)) dut (
    .pxl_clk(pxl_clk), .rst(rst), .video_de(de), .video_hsync(hs), .video_vsync(vs),
    .h_active(h_active), .h_total(h_total), .v_active(v_active), .v_total(v_total),
    .meas_valid(meas_valid), .fps(fps), .fps_valid(fps_valid), .locked(locked),
    .timing_changed(timing_changed));

  video_timing_meas #(.PXL_CLK_FREQ_HZ(2000), .CNT_W(4), .FPS_W(8),
                      .CLK_PER_PIXEL(1), .STABLE_FRAMES(3)) dut_sat (
    .pxl_clk(pxl_clk), .rst(rst), .video_de(de), .video_hsync(hs), .video_vsync(vs),
    .h_active(s_h_active), .h_total(s_h_total), .v_active(s_v_active), .v_total(s_v_total),
    .meas_valid(s_meas_valid), .fps(s_fps), .fps_valid(s_fps_valid), .locked(s_locked),
    .timing_changed(s_timing_changed));

  video_timing_meas #(.PXL_CLK_FREQ_HZ(2000), .CNT_W(16), .FPS_W(8),
                      .CLK_PER_PIXEL(2), .STABLE_FRAMES(3)) dut2 (
    .pxl_clk(pxl_clk), .rst(rst), .video_de(de2), .video_hsync(hs2), .video_vsync(vs2),
    .h_active(d_h_active), .h_total(d_h_total), .v_active(d_v_active), .v_total(d_v_total),
    .meas_valid(d_meas_valid), .fps(d_fps), .fps_valid(d_fps_valid), .locked(d_locked),
    .timing_changed(d_timing_changed));

  // Pulse monitors on the main instance, sampled away from the active edge
  always @(negedge pxl_clk) begin
    if (meas_valid) mv_cnt++;
    if (timing_changed) tc_cnt++;
    if (fps_valid) begin
      fv_cnt++;
      last_fps = int'(fps);
    end
  end

  task automatic pix(input logic d, input logic h, input logic v, input bit sel2);
    if (sel2) begin
      de2 = d; hs2 = h; vs2 = v;
      de = 1'b0; hs = 1'b0; vs = 1'b0;
    end else begin
      de = d; hs = h; vs = v;
      de2 = 1'b0; hs2 = 1'b0; vs2 = 1'b0;
    end
    @(posedge pxl_clk);
    #1;
  endtask

  // Lines of 20*scl clocks: hsync 2*scl, DE de_w*scl starting at 4*scl on lines 2..7, vsync on line 0
  task automatic frame(input int de_w, input int scl, input bit sel2, input bit vs_en,
                       input int n_lines);
    for (int l = 0; l < n_lines; l++) begin
      for (int p = 0; p < 20 * scl; p++) begin
        pix((l >= 2 && l <= 7 && p >= 4 * scl && p < (4 + de_w) * scl),
            (p < 2 * scl), (vs_en && l == 0), sel2);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({h_active, h_total, v_active, v_total, fps, meas_valid, fps_valid, locked,
         timing_changed} !== '0) begin
      errors++;
      $display("FAIL %s main: got h=%0d ht=%0d v=%0d vt=%0d fps=%0d mv=%b fv=%b lk=%b tc=%b required all 0",
               name, h_active, h_total, v_active, v_total, fps, meas_valid, fps_valid,
               locked, timing_changed);
    end
    checks++;
    if ({s_h_active, s_h_total, s_v_active, s_v_total, s_fps, s_meas_valid, s_fps_valid,
         s_locked, s_timing_changed, d_h_active, d_h_total, d_v_active, d_v_total, d_fps,
         d_meas_valid, d_fps_valid, d_locked, d_timing_changed} !== '0) begin
      errors++;
      $display("FAIL %s other instances: outputs nonzero, required all 0", name);
    end
  endtask

  task automatic check_meas(input string name, input int ha, input int ht, input int va,
                            input int vt);
    checks++;
    if (h_active !== 16'(ha) || h_total !== 16'(ht) || v_active !== 16'(va) ||
        v_total !== 16'(vt)) begin
      errors++;
      $display("FAIL %s: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", name,
               h_active, h_total, v_active, v_total, ha, ht, va, vt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pix(1'b1, 1'b1, 1'b1, 1'b0);
    pix(1'b1, 1'b0, 1'b1, 1'b1);
    pix(1'b0, 1'b0, 1'b0, 1'b0);
    check_all_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_basic;
    frame(12, 1, 1'b0, 1'b1, 10);
    checks++;
    if (mv_cnt !== 0 || h_active !== 16'd0) begin
      errors++;
      $display("FAIL first_vsync_arm_only: got mv pulses %0d h_active %0d required 0 0",
               mv_cnt, h_active);
    end
    frame(12, 1, 1'b0, 1'b1, 10);
    check_meas("basic_meas", 12, 20, 6, 10);
    checks++;
    if (mv_cnt !== 1) begin
      errors++;
      $display("FAIL basic_meas_valid: got %0d pulse cycles required 1", mv_cnt);
    end
    checks++;
    if (s_h_active !== 4'd12 || s_h_total !== 4'd15 || s_v_active !== 4'd6 ||
        s_v_total !== 4'd10) begin
      errors++;
      $display("FAIL saturation_cnt_w4: got %0d/%0d/%0d/%0d required 12/15/6/10",
               s_h_active, s_h_total, s_v_active, s_v_total);
    end
  endtask

  task automatic test_lock_fps;
    frame(12, 1, 1'b0, 1'b1, 10);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_after_3rd_rise: got %b required 0", locked);
    end
    frame(12, 1, 1'b0, 1'b1, 10);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_after_4th_rise: got %b required 1", locked);
    end
    for (int i = 0; i < 8; i++) frame(12, 1, 1'b0, 1'b1, 10);
    checks++;
    if (fps !== 8'd10 || last_fps !== 10 || fv_cnt !== 1) begin
      errors++;
      $display("FAIL fps_window: got fps %0d seen %0d fv pulses %0d required 10 10 1",
               fps, last_fps, fv_cnt);
    end
    checks++;
    if (tc_cnt !== 0 || mv_cnt !== 11) begin
      errors++;
      $display("FAIL stable_stream_pulses: got tc %0d mv %0d required 0 11", tc_cnt, mv_cnt);
    end
  endtask

  task automatic test_change;
    int tc0;
    tc0 = tc_cnt;
    frame(14, 1, 1'b0, 1'b1, 10);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL change_before_publish: got locked %b required 1", locked);
    end
    frame(12, 1, 1'b0, 1'b1, 10);
    check_meas("changed_meas", 14, 20, 6, 10);
    checks++;
    if (locked !== 1'b0 || tc_cnt !== tc0 + 1) begin
      errors++;
      $display("FAIL change_detect: got locked %b tc %0d required 0 %0d", locked, tc_cnt, tc0 + 1);
    end
    frame(12, 1, 1'b0, 1'b1, 10);
    frame(12, 1, 1'b0, 1'b1, 10);
    checks++;
    if (locked !== 1'b0 || tc_cnt !== tc0 + 2 || h_active !== 16'd12) begin
      errors++;
      $display("FAIL relock_pending: got locked %b tc %0d h %0d required 0 %0d 12",
               locked, tc_cnt, h_active, tc0 + 2);
    end
    frame(12, 1, 1'b0, 1'b1, 10);
    checks++;
    if (locked !== 1'b1 || tc_cnt !== tc0 + 2) begin
      errors++;
      $display("FAIL relock: got locked %b tc %0d required 1 %0d", locked, tc_cnt, tc0 + 2);
    end
  endtask

  task automatic test_video_loss;
    int mv0;
    mv0 = mv_cnt;
    for (int i = 0; i < 24; i++) frame(12, 1, 1'b0, 1'b0, 10);
    checks++;
    if (last_fps !== 0 || fps !== 8'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL video_loss: got fps %0d seen %0d locked %b required 0 0 0",
               fps, last_fps, locked);
    end
    checks++;
    if (mv_cnt !== mv0 || fv_cnt !== 4) begin
      errors++;
      $display("FAIL video_loss_pulses: got mv %0d fv %0d required %0d 4", mv_cnt, fv_cnt, mv0);
    end
  endtask

  task automatic test_reset_midframe;
    int mv0, tc0;
    for (int i = 0; i < 4; i++) frame(12, 1, 1'b0, 1'b1, 10);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock_after_loss: got %b required 1", locked);
    end
    frame(12, 1, 1'b0, 1'b1, 4);
    rst = 1'b1;
    pix(1'b0, 1'b0, 1'b0, 1'b0);
    check_all_zero("midframe_reset");
    rst = 1'b0;
    mv0 = mv_cnt;
    tc0 = tc_cnt;
    frame(12, 1, 1'b0, 1'b1, 10);
    checks++;
    if (mv_cnt !== mv0 || h_active !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_first_rise: got mv %0d h %0d required %0d 0",
               mv_cnt - mv0, h_active, 0);
    end
    frame(12, 1, 1'b0, 1'b1, 10);
    check_meas("post_reset_meas", 12, 20, 6, 10);
    checks++;
    if (mv_cnt !== mv0 + 1 || tc_cnt !== tc0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_pulses: got mv %0d tc %0d locked %b required 1 0 0",
               mv_cnt - mv0, tc_cnt - tc0, locked);
    end
  endtask

  task automatic test_clk_per_pixel2;
    frame(12, 2, 1'b1, 1'b1, 10);
    frame(12, 2, 1'b1, 1'b1, 10);
    checks++;
    if (d_h_active !== 16'd12 || d_h_total !== 16'd20 || d_v_active !== 16'd6 ||
        d_v_total !== 16'd10 || d_locked !== 1'b0) begin
      errors++;
      $display("FAIL clk_per_pixel2: got %0d/%0d/%0d/%0d lk %b required 12/20/6/10 0",
               d_h_active, d_h_total, d_v_active, d_v_total, d_locked);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lock_fps();
    test_change();
    test_video_loss();
    test_reset_midframe();
    test_clk_per_pixel2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_meas.md
VIDEO_TIMING_MEAS -- requirements
Module: video_timing_meas

Interface
REQ-001 SHALL have parameter PXL_CLK_FREQ_HZ, default 74_250_000, pxl_clk frequency; it sets the 1 s fps window.
REQ-002 SHALL have parameter CNT_W, default 16, width of all H/V measurement outputs.
REQ-003 SHALL have parameter FPS_W, default 8, width of fps output.
REQ-004 SHALL have parameter CLK_PER_PIXEL, default 1, legal values 1 or 2, pxl_clk cycles per pixel.
REQ-005 SHALL have parameter STABLE_FRAMES, default 3, range 1..15, consecutive identical frames required for lock.
REQ-006 SHALL have port pxl_clk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have ports video_de / video_hsync / video_vsync  in  1 each  DE, hsync, vsync; hsync and vsync are active-high.
REQ-009 SHALL have ports h_active / h_total  out  CNT_W each  active pixels per line; pixels from one DE rise to the next.
REQ-010 SHALL have ports v_active / v_total  out  CNT_W each  DE lines per frame; hsync pulses per frame.
REQ-011 SHALL have port meas_valid  out  1  one-cycle pulse when frame results update.
REQ-012 SHALL have port fps  out  FPS_W  vsync rising edges in the last 1 s window.
REQ-013 SHALL have port fps_valid  out  1  one-cycle pulse when fps updates.
REQ-014 SHALL have ports locked  out  1  timing stable, and timing_changed  out  1  one-cycle pulse on mismatch.

Function
REQ-015 SHALL register each input once; a rising (falling) edge is detected when the input is 1 (0) and its registered copy is 0 (1).
REQ-016 SHALL count DE-high cycles per line and divide the count by CLK_PER_PIXEL (for 2, take count>>1).
REQ-017 SHALL latch the line value into an internal h_active register on each DE falling edge.
REQ-018 SHALL count cycles between consecutive DE rising edges, divided by CLK_PER_PIXEL, into an internal h_total register.
  - The first DE rise after reset only starts this count.
REQ-019 SHALL count DE rising edges (v_active) and hsync rising edges (v_total) between consecutive vsync rising edges.
REQ-020 SHALL update outputs on the cycle after a vsync rising edge:
  - h_active, h_total, v_active, v_total take the latest values and meas_valid pulses for 1 cycle.
  - The first vsync rise after reset only arms counting: no update and no pulse.
REQ-021 SHALL saturate every counter at its all-ones value; no wrap-around.
REQ-022 SHALL count a DE or hsync rising edge that coincides with a vsync rising edge in the new frame.
REQ-023 SHALL, at each update, compare the new {h_active,h_total,v_active,v_total} with the previously published set:
  - Equal and v_active≠0: increment the match counter, saturating at STABLE_FRAMES.
  - Otherwise: clear the match counter and deassert locked.
  - timing_changed pulses only if the previous set was nonzero.
REQ-024 SHALL assert locked when the match counter reaches STABLE_FRAMES−1 identical comparisons, i.e. STABLE_FRAMES identical frames.
REQ-025 SHALL generate a 1 s tick every PXL_CLK_FREQ_HZ cycles; on the tick, fps takes the window's vsync-rise count, fps_valid pulses, and the count restarts at 0.
  - A vsync rise coinciding with the tick is counted in the closing window.
REQ-026 SHALL clear locked on a tick whose window counted zero vsync edges (video loss).

Reset
REQ-027 SHALL, when rst=1 at a clock edge, clear all counters, edge registers, arm flags and match counter.
REQ-028 SHALL hold all outputs at 0 during reset (h_active, h_total, v_active, v_total, fps, meas_valid, fps_valid, locked, timing_changed).
REQ-029 SHALL, on reset asserted mid-frame, discard the partial frame; measurement resumes per REQ-020 after release.

Verification
REQ-030 Use PXL_CLK_FREQ_HZ=2000, CLK_PER_PIXEL=1, STABLE_FRAMES=3, line 20 clk (DE 12, hsync 2), frame 10 lines (DE lines 6, vsync 1 line) -> after 2nd vsync rise: h_active=12, h_total=20, v_active=6, v_total=10, meas_valid one pulse.
REQ-031 Run the same stream continuously -> locked=1 after the update of the 4th vsync rise (3 identical frames); timing_changed never pulses; fps=10, fps_valid pulses each 2000 cycles.
REQ-032 While locked, change DE to 14 clk for one frame -> next update h_active=14, timing_changed pulse, locked=0; relock after 3 further identical frames.
REQ-033 Set CLK_PER_PIXEL=2 with every timing doubled -> h_active=12, h_total=20, v_active=6, v_total=10.
REQ-034 Stop vsync (DE toggling) for >2000 cycles -> next tick fps=0, fps_valid pulse, locked=0, no meas_valid.
REQ-035 Assert rst for 1 cycle mid-frame while locked -> all outputs 0 next cycle; the first vsync rise after release gives no meas_valid; valid data returns on the second.
